// File: rtl/sound_length_bank_pkg.sv
// Shared constants and helpers for the APU length-counter bank.
package sound_length_bank_pkg;

  localparam int unsigned NUM_CH_DEF    = 4;
  localparam int unsigned WIDTH_MAX_DEF = 8;
  localparam logic [3:0]  WIDE_MASK_DEF = 4'b0100;

  // Narrow channels (1, 2, 4) carry a 6-bit length field.
  localparam int unsigned LEN_NARROW = 6;

  // NRx4 bit positions.
  localparam int unsigned NRX4_TRIGGER_BIT = 7;
  localparam int unsigned NRX4_LEN_EN_BIT  = 6;

  // Full-scale count N for a slot: 2^WIDTH_MAX when wide, 64 otherwise.
  function automatic int unsigned slot_max(input int unsigned width_max, input logic wide);
    return wide ? (32'd1 << width_max) : (32'd1 << LEN_NARROW);
  endfunction

endpackage

// File: rtl/sound_length_bank_if.sv
// Register-file / generator side signals of the length-counter bank.
interface sound_length_bank_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH_MAX = 8
);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 clk_length_ctr;
  logic                 fs_skip_next;
  logic [SEL_W-1:0]     ch_sel;
  logic                 wr_length;
  logic [WIDTH_MAX-1:0] wr_data;
  logic                 wr_ctrl;
  logic                 ctrl_len_en;
  logic                 ctrl_trigger;
  logic [NUM_CH-1:0]    dac_en;
  logic [NUM_CH-1:0]    enable;
  logic [NUM_CH-1:0]    len_en_q;

  modport master (
    output clk_length_ctr, fs_skip_next, ch_sel, wr_length, wr_data,
           wr_ctrl, ctrl_len_en, ctrl_trigger, dac_en,
    input  enable, len_en_q
  );

  modport slave (
    input  clk_length_ctr, fs_skip_next, ch_sel, wr_length, wr_data,
           wr_ctrl, ctrl_len_en, ctrl_trigger, dac_en,
    output enable, len_en_q
  );
endinterface

// File: rtl/sound_length_bank_slice.sv
// One length-counter slot: down-counter with DMG extra-clock and trigger-reload quirks.
module sound_length_slice
  import sound_length_bank_pkg::*;
#(
  parameter int unsigned WIDTH_MAX = 8,
  parameter bit          WIDE      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 skip,
  input  logic                 wr_len,
  input  logic [WIDTH_MAX-1:0] wr_data,
  input  logic                 wr_ctrl,
  input  logic                 len_en,
  input  logic                 trig,
  input  logic                 dac,
  output logic                 enable,
  output logic                 len_en_q
);
  localparam int unsigned    CW   = WIDTH_MAX + 1;
  localparam int unsigned    LW   = WIDE ? WIDTH_MAX : LEN_NARROW;
  localparam logic [CW-1:0]  N    = CW'(slot_max(WIDTH_MAX, WIDE));
  localparam logic [WIDTH_MAX-1:0] MASK = WIDTH_MAX'((CW'(1) << LW) - CW'(1));

  logic [CW-1:0] ctr, ctr_ld, ctr_nxt;
  logic          en_nxt, len_nxt, extra;

  // Next-state: length load first, then NRx4 rules, else the frame-sequencer tick.
  always_comb begin
    ctr_ld  = wr_len ? (N - CW'(wr_data & MASK)) : ctr;
    ctr_nxt = ctr_ld;
    en_nxt  = enable;
    len_nxt = len_en_q;
    extra   = wr_ctrl && skip && !len_en_q && len_en && (ctr_ld != '0);
    if (wr_ctrl) begin
      len_nxt = len_en;
      if (extra) begin
        ctr_nxt = ctr_ld - CW'(1);
        if ((ctr_nxt == '0) && !trig) en_nxt = 1'b0;
      end
      if (trig) begin
        en_nxt = 1'b1;
        if (ctr_nxt == '0) ctr_nxt = (len_en && skip) ? (N - CW'(1)) : N;
      end
    end else if (!wr_len && tick && len_en_q && (ctr != '0)) begin
      ctr_nxt = ctr - CW'(1);
      if (ctr_nxt == '0) en_nxt = 1'b0;
    end
    if (!dac) en_nxt = 1'b0;
  end

  // Slot state register; reset doubles as APU power-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr      <= '0;
      enable   <= 1'b0;
      len_en_q <= 1'b0;
    end else begin
      ctr      <= ctr_nxt;
      enable   <= en_nxt;
      len_en_q <= len_nxt;
    end
  end
endmodule

// File: rtl/sound_length_bank.sv
// Multi-channel length-counter bank: decodes per-slot strobes and broadcasts the tick.
module sound_length_bank
  import sound_length_bank_pkg::*;
#(
  parameter int unsigned         NUM_CH    = NUM_CH_DEF,
  parameter int unsigned         WIDTH_MAX = WIDTH_MAX_DEF,
  parameter logic [NUM_CH-1:0]   WIDE_MASK = NUM_CH'(WIDE_MASK_DEF)
) (
  input logic                 clk,
  input logic                 rst,
  sound_length_bank_if.slave  bus
);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en_w;
  logic [NUM_CH-1:0] len_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    logic hit;
    assign hit = (bus.ch_sel == SEL_W'(i));

    sound_length_slice #(
      .WIDTH_MAX (WIDTH_MAX),
      .WIDE      (WIDE_MASK[i])
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .tick     (bus.clk_length_ctr),
      .skip     (bus.fs_skip_next),
      .wr_len   (bus.wr_length && hit),
      .wr_data  (bus.wr_data),
      .wr_ctrl  (bus.wr_ctrl && hit),
      .len_en   (bus.ctrl_len_en),
      .trig     (bus.ctrl_trigger),
      .dac      (bus.dac_en[i]),
      .enable   (en_w[i]),
      .len_en_q (len_w[i])
    );
  end

  assign bus.enable   = en_w;
  assign bus.len_en_q = len_w;
endmodule

// File: tb/tb_sound_length_bank.sv
// Self-checking bench for sound_length_bank: directed DMG-quirk scenarios plus random traffic.
module tb_sound_length_bank;
  import sound_length_bank_pkg::*;

  localparam int unsigned NCH = 4;
  localparam logic [3:0]  WMASK = 4'b0100;

  logic clk, rst;
  int   vectors = 0;
  int   miscompares = 0;

  int   m_ctr [NCH];
  bit   m_en  [NCH];
  bit   m_len [NCH];

  sound_length_bank_if #(.NUM_CH(NCH), .WIDTH_MAX(8)) bus ();

  sound_length_bank #(.NUM_CH(NCH), .WIDTH_MAX(8), .WIDE_MASK(WMASK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply this cycle's inputs to the per-slot counters using plain integers.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int n = WMASK[i] ? 256 : 64;
      bit sel = (int'(bus.ch_sel) == i);
      bit wl = bus.wr_length && sel;
      bit wc = bus.wr_ctrl && sel;
      int c = m_ctr[i];
      bit e = m_en[i];
      bit l = m_len[i];
      if (rst) begin
        c = 0; e = 0; l = 0;
      end else begin
        if (wl) c = n - (int'(bus.wr_data) % n);
        if (wc) begin
          if (bus.fs_skip_next && !l && bus.ctrl_len_en && c > 0) begin
            c = c - 1;
            if (c == 0 && !bus.ctrl_trigger) e = 0;
          end
          if (bus.ctrl_trigger) begin
            e = 1;
            if (c == 0) c = (bus.ctrl_len_en && bus.fs_skip_next) ? n - 1 : n;
          end
          l = bus.ctrl_len_en;
        end else if (!wl && bus.clk_length_ctr && l && c > 0) begin
          c = c - 1;
          if (c == 0) e = 0;
        end
        if (!bus.dac_en[i]) e = 0;
      end
      m_ctr[i] = c; m_en[i] = e; m_len[i] = l;
    end
  endtask

  // One clock: update the model, let the edge pass, compare at the falling edge, clear pulses.
  task automatic apply();
    int exp_en, exp_len;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_en = 0; exp_len = 0;
    for (int i = 0; i < NCH; i++) begin
      exp_en  |= int'(m_en[i])  << i;
      exp_len |= int'(m_len[i]) << i;
    end
    chk("enable",   int'(bus.enable),   exp_en);
    chk("len_en_q", int'(bus.len_en_q), exp_len);
    rst                = 1'b0;
    bus.wr_length      = 1'b0;
    bus.wr_ctrl        = 1'b0;
    bus.clk_length_ctr = 1'b0;
    bus.ctrl_trigger   = 1'b0;
    bus.ctrl_len_en    = 1'b0;
  endtask

  task automatic wr_len(input int sel, input int data);
    bus.ch_sel    = 2'(sel);
    bus.wr_length = 1'b1;
    bus.wr_data   = 8'(data);
    apply();
  endtask

  task automatic wr_nrx4(input int sel, input bit len_en, input bit trig, input bit skip);
    logic [7:0] nrx4;
    nrx4 = '0;
    nrx4[NRX4_LEN_EN_BIT]  = len_en;
    nrx4[NRX4_TRIGGER_BIT] = trig;
    bus.ch_sel       = 2'(sel);
    bus.wr_ctrl      = 1'b1;
    bus.ctrl_len_en  = nrx4[NRX4_LEN_EN_BIT];
    bus.ctrl_trigger = nrx4[NRX4_TRIGGER_BIT];
    bus.fs_skip_next = skip;
    apply();
  endtask

  task automatic tick();
    bus.clk_length_ctr = 1'b1;
    apply();
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_length_ctr = 0; bus.fs_skip_next = 0; bus.ch_sel = 0;
    bus.wr_length = 0; bus.wr_data = 0; bus.wr_ctrl = 0;
    bus.ctrl_len_en = 0; bus.ctrl_trigger = 0; bus.dac_en = 4'hF;
    for (int i = 0; i < NCH; i++) begin m_ctr[i] = 0; m_en[i] = 0; m_len[i] = 0; end

    // Reset state
    apply();
    chk("reset_enable", int'(bus.enable), 0);
    chk("reset_len_en_q", int'(bus.len_en_q), 0);

    // 1: narrow slot 0, data 62 -> two ticks to expire
    wr_len(0, 62);
    wr_nrx4(0, 1'b1, 1'b1, 1'b0);
    chk("t1_enable_after_trigger", int'(bus.enable[0]), 1);
    chk("t1_len_en_q", int'(bus.len_en_q[0]), 1);
    tick();
    chk("t1_enable_after_tick1", int'(bus.enable[0]), 1);
    tick();
    chk("t1_enable_after_tick2", int'(bus.enable[0]), 0);

    // 2: wide slot 2, data 0 -> 256 ticks
    wr_len(2, 0);
    wr_nrx4(2, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 255; k++) tick();
    chk("t2_enable_after_255", int'(bus.enable[2]), 1);
    tick();
    chk("t2_enable_after_256", int'(bus.enable[2]), 0);

    // 3: extra clock on length-enable with ctr=1
    wr_len(1, 63);
    wr_nrx4(1, 1'b0, 1'b1, 1'b0);
    chk("t3_enable_running", int'(bus.enable[1]), 1);
    wr_nrx4(1, 1'b1, 1'b0, 1'b1);
    chk("t3_enable_extra_clock", int'(bus.enable[1]), 0);
    chk("t3_model_ctr", m_ctr[1], 0);

    // 4: trigger with ctr=0, len_en=1, skip=1 -> reload 63
    wr_nrx4(1, 1'b1, 1'b1, 1'b1);
    chk("t4_model_ctr", m_ctr[1], 63);
    bus.fs_skip_next = 1'b0;
    for (int k = 0; k < 62; k++) tick();
    chk("t4_enable_after_62", int'(bus.enable[1]), 1);
    tick();
    chk("t4_enable_after_63", int'(bus.enable[1]), 0);

    // 5: length write on slot 0 coinciding with a tick
    wr_nrx4(1, 1'b1, 1'b1, 1'b0);
    bus.clk_length_ctr = 1'b1;
    wr_len(0, 10);
    chk("t5_slot0_held", m_ctr[0], 54);
    chk("t5_slot1_ticked", m_ctr[1], 63);

    // 6: reset mid-count with all channels running
    for (int i = 0; i < NCH; i++) wr_nrx4(i, 1'b1, 1'b1, 1'b0);
    chk("t6_all_enabled", int'(bus.enable), 15);
    tick();
    chk("t6_still_enabled", int'(bus.enable), 15);
    rst = 1'b1;
    bus.clk_length_ctr = 1'b1;
    apply();
    chk("t6_enable_after_rst", int'(bus.enable), 0);
    chk("t6_len_after_rst", int'(bus.len_en_q), 0);
    for (int k = 0; k < 3; k++) tick();
    chk("t6_enable_ticks_after_rst", int'(bus.enable), 0);
    wr_nrx4(3, 1'b0, 1'b1, 1'b0);
    chk("t6_ctr_reloaded_from_zero", m_ctr[3], 64);
    chk("t6_enable3_trigger", int'(bus.enable), 8);

    // dac low kills the channel without touching the count
    bus.dac_en = 4'b0111;
    apply();
    chk("dac_off_enable", int'(bus.enable), 0);
    bus.dac_en = 4'hF;

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rst                = ($urandom_range(0, 299) == 0);
      bus.clk_length_ctr = ($urandom_range(0, 3) == 0);
      bus.fs_skip_next   = 1'($urandom_range(0, 1));
      bus.ch_sel         = 2'($urandom_range(0, 3));
      bus.wr_length      = ($urandom_range(0, 9) == 0);
      bus.wr_data        = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(56, 255)) : 8'($urandom);
      bus.wr_ctrl        = ($urandom_range(0, 7) == 0);
      bus.ctrl_len_en    = ($urandom_range(0, 3) != 0);
      bus.ctrl_trigger   = 1'($urandom_range(0, 1));
      for (int i = 0; i < NCH; i++) bus.dac_en[i] = ($urandom_range(0, 31) != 0);
      apply();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
